buzzer_scheduler: RTL and testbench

Sequences the digital clock's single piezo buzzer and shares it between three requesters: the alarm, the hourly chime and key-press beeps. It sits between the timekeeping/alarm-compare logic and the buzzer pin, next to the sound-detect control. It resolves priority, times every beep in millisecond ticks and generates the square-wave tone. It also lets a key press silence a ringing alarm.

---
 rtl/buzzer_pkg.sv | 56 +++++
 rtl/buzzer_scheduler_tone_gen.sv | 60 ++++++
 rtl/buzzer_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_buzzer_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
// Shared types and helpers for the buzzer scheduler: FSM states, source codes,
// chime-count clamping and small constant helpers.
package buzzer_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        KEY_ON    = 3'd1,
        CHIME_ON  = 3'd2,
        CHIME_GAP = 3'd3,
        ALARM_ON  = 3'd4,
        ALARM_OFF = 3'd5
    } state_e;

    typedef logic [1:0] src_t;

    localparam src_t SRC_NONE  = 2'b00;
    localparam src_t SRC_KEY   = 2'b01;
    localparam src_t SRC_CHIME = 2'b10;
    localparam src_t SRC_ALARM = 2'b11;

    localparam logic [3:0] CHIME_MAX = 4'd12;

    function automatic int max2(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    function automatic logic [3:0] clamp_chime(input logic [3:0] count);
        if (count > CHIME_MAX) begin
            return CHIME_MAX;
        end else begin
            return count;
        end
    endfunction

    function automatic src_t src_of(input state_e st);
        case (st)
            KEY_ON:              return SRC_KEY;
            CHIME_ON, CHIME_GAP: return SRC_CHIME;
            ALARM_ON, ALARM_OFF: return SRC_ALARM;
            default:             return SRC_NONE;
        endcase
    endfunction

    // Only these states drive the tone onto the pin.
    function automatic logic is_on(input state_e st);
        case (st)
            KEY_ON, CHIME_ON, ALARM_ON: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/buzzer_scheduler_tone_gen.sv
// Square-wave divider: phase restarts high on request and toggles every
// half-period; the half-period is chosen between a high and a low tone.
module tone_gen
    import buzzer_pkg::*;
#(
    parameter int HI_DIV = 25000,
    parameter int LO_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic sel_lo,
    output logic phase_next
);

    localparam int MAX_DIV = max2(HI_DIV, LO_DIV);
    localparam int TW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

    localparam logic [TW-1:0] HI_LAST = TW'(HI_DIV - 1);
    localparam logic [TW-1:0] LO_LAST = TW'(LO_DIV - 1);
    localparam logic [TW-1:0] CNT_ONE = TW'(1);

    logic [TW-1:0] cnt_r;
    logic [TW-1:0] cnt_next_s;
    logic [TW-1:0] last_s;
    logic          phase_r;

    // Next half-period count and phase; a restart forces the phase high.
    always_comb begin
        cnt_next_s = cnt_r;
        phase_next = phase_r;
        if (sel_lo) begin
            last_s = LO_LAST;
        end else begin
            last_s = HI_LAST;
        end
        if (restart) begin
            cnt_next_s = '0;
            phase_next = 1'b1;
        end else if (cnt_r >= last_s) begin
            cnt_next_s = '0;
            phase_next = ~phase_r;
        end else begin
            cnt_next_s = cnt_r + CNT_ONE;
            phase_next = phase_r;
        end
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            phase_r <= 1'b0;
        end else begin
            cnt_r   <= cnt_next_s;
            phase_r <= phase_next;
        end
    end

endmodule

// File: rtl/buzzer_scheduler.sv
// Shares one piezo buzzer between alarm, hourly chime and key beeps: resolves
// priority, times each beep in millisecond ticks and gates the tone onto the pin.
module buzzer_scheduler
    import buzzer_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int TONE_HI_DIV  = 25000,
    parameter int TONE_LO_DIV  = 50000,
    parameter int KEY_MS       = 50,
    parameter int BEEP_MS      = 200,
    parameter int GAP_MS       = 200,
    parameter int ALARM_ON_MS  = 500,
    parameter int ALARM_OFF_MS = 500
) (
    input  logic       clk_100MHz,
    input  logic       rst_buzzer,
    input  logic       alarm_req,
    input  logic       chime_req,
    input  logic [3:0] chime_count,
    input  logic       key_req,
    input  logic       mute,
    output logic       buzzer,
    output logic       busy,
    output logic [1:0] active_src,
    output logic       alarm_silenced
);

    localparam int MAX_MS  = max2(max2(KEY_MS, BEEP_MS),
                                  max2(GAP_MS, max2(ALARM_ON_MS, ALARM_OFF_MS)));
    localparam int MAX_CYC = MAX_MS * TICK_DIV;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t KEY_LAST   = cnt_t'(KEY_MS * TICK_DIV - 1);
    localparam cnt_t BEEP_LAST  = cnt_t'(BEEP_MS * TICK_DIV - 1);
    localparam cnt_t GAP_LAST   = cnt_t'(GAP_MS * TICK_DIV - 1);
    localparam cnt_t AON_LAST   = cnt_t'(ALARM_ON_MS * TICK_DIV - 1);
    localparam cnt_t AOFF_LAST  = cnt_t'(ALARM_OFF_MS * TICK_DIV - 1);
    localparam cnt_t CNT_ONE    = cnt_t'(1);

    state_e     state_r;
    state_e     next_state_s;
    cnt_t       dur_r;
    cnt_t       dur_next_s;
    cnt_t       dur_last_s;
    logic       done_s;
    logic       restart_s;
    logic [3:0] beeps_r;
    logic [3:0] beeps_next_s;
    logic       key_pend_r;
    logic       key_pend_next_s;
    logic       silenced_r;
    logic       silenced_next_s;
    logic       alarm_go_s;
    logic       chime_ok_s;
    logic       sel_lo_s;
    logic       phase_next_s;
    logic       buzzer_r;
    logic       busy_r;
    src_t       active_src_r;

    assign alarm_go_s = alarm_req & ~silenced_r;
    assign chime_ok_s = chime_req & (chime_count != 4'd0);

    // Length of the current state in clk cycles, minus one.
    always_comb begin
        case (state_r)
            KEY_ON:    dur_last_s = KEY_LAST;
            CHIME_ON:  dur_last_s = BEEP_LAST;
            CHIME_GAP: dur_last_s = GAP_LAST;
            ALARM_ON:  dur_last_s = AON_LAST;
            ALARM_OFF: dur_last_s = AOFF_LAST;
            default:   dur_last_s = '0;
        endcase
    end

    assign done_s = (dur_r == dur_last_s);

    // Next-state, beep count, pending-key and snooze decisions.
    always_comb begin
        next_state_s    = state_r;
        beeps_next_s    = beeps_r;
        key_pend_next_s = key_pend_r;
        silenced_next_s = silenced_r;
        case (state_r)
            IDLE: begin
                if (alarm_go_s) begin
                    next_state_s    = ALARM_ON;
                    key_pend_next_s = 1'b0;
                end else if (chime_ok_s) begin
                    next_state_s    = CHIME_ON;
                    beeps_next_s    = clamp_chime(chime_count);
                    key_pend_next_s = key_pend_r | key_req;
                end else if (key_req || key_pend_r) begin
                    next_state_s    = KEY_ON;
                    key_pend_next_s = 1'b0;
                end else begin
                    next_state_s    = IDLE;
                end
            end
            KEY_ON: begin
                if (alarm_go_s) begin
                    next_state_s    = ALARM_ON;
                    key_pend_next_s = 1'b0;
                end else if (done_s) begin
                    next_state_s    = IDLE;
                end else begin
                    next_state_s    = KEY_ON;
                end
            end
            CHIME_ON: begin
                if (alarm_go_s) begin
                    next_state_s    = ALARM_ON;
                    key_pend_next_s = 1'b0;
                    beeps_next_s    = 4'd0;
                end else begin
                    key_pend_next_s = key_pend_r | key_req;
                    if (done_s && (beeps_r <= 4'd1)) begin
                        next_state_s = IDLE;
                        beeps_next_s = 4'd0;
                    end else if (done_s) begin
                        next_state_s = CHIME_GAP;
                        beeps_next_s = beeps_r - 4'd1;
                    end else begin
                        next_state_s = CHIME_ON;
                    end
                end
            end
            CHIME_GAP: begin
                if (alarm_go_s) begin
                    next_state_s    = ALARM_ON;
                    key_pend_next_s = 1'b0;
                    beeps_next_s    = 4'd0;
                end else begin
                    key_pend_next_s = key_pend_r | key_req;
                    if (done_s) begin
                        next_state_s = CHIME_ON;
                    end else begin
                        next_state_s = CHIME_GAP;
                    end
                end
            end
            ALARM_ON, ALARM_OFF: begin
                if (!alarm_req) begin
                    next_state_s = IDLE;
                end else if (key_req) begin
                    // Snooze: the key stops the alarm and makes no beep itself.
                    next_state_s    = IDLE;
                    silenced_next_s = 1'b1;
                end else if (done_s && (state_r == ALARM_ON)) begin
                    next_state_s = ALARM_OFF;
                end else if (done_s) begin
                    next_state_s = ALARM_ON;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s    = IDLE;
                beeps_next_s    = 4'd0;
                key_pend_next_s = 1'b0;
                silenced_next_s = 1'b0;
            end
        endcase
        if (!alarm_req) begin
            silenced_next_s = 1'b0;
        end else begin
            silenced_next_s = silenced_next_s;
        end
    end

    // Every state entry restarts both the duration counter and the tone.
    always_comb begin
        restart_s = (next_state_s != state_r);
        sel_lo_s  = (next_state_s == CHIME_ON);
        if (restart_s) begin
            dur_next_s = '0;
        end else if (!done_s) begin
            dur_next_s = dur_r + CNT_ONE;
        end else begin
            dur_next_s = dur_r;
        end
    end

    tone_gen #(
        .HI_DIV (TONE_HI_DIV),
        .LO_DIV (TONE_LO_DIV)
    ) u_tone_gen (
        .clk        (clk_100MHz),
        .rst        (rst_buzzer),
        .restart    (restart_s),
        .sel_lo     (sel_lo_s),
        .phase_next (phase_next_s)
    );

    // State, counters and outputs; outputs are registered from next-state values
    // so they change together in the cycle following a decision edge.
    always_ff @(posedge clk_100MHz) begin
        if (rst_buzzer) begin
            state_r      <= IDLE;
            dur_r        <= '0;
            beeps_r      <= 4'd0;
            key_pend_r   <= 1'b0;
            silenced_r   <= 1'b0;
            buzzer_r     <= 1'b0;
            busy_r       <= 1'b0;
            active_src_r <= SRC_NONE;
        end else begin
            state_r      <= next_state_s;
            dur_r        <= dur_next_s;
            beeps_r      <= beeps_next_s;
            key_pend_r   <= key_pend_next_s;
            silenced_r   <= silenced_next_s;
            buzzer_r     <= is_on(next_state_s) & phase_next_s & ~mute;
            busy_r       <= (next_state_s != IDLE);
            active_src_r <= src_of(next_state_s);
        end
    end

    assign buzzer         = buzzer_r;
    assign busy           = busy_r;
    assign active_src     = active_src_r;
    assign alarm_silenced = silenced_r;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Scoreboarded bench: a per-cycle activity/time reference model predicts every
// output; a negedge monitor pops predictions and compares them with the DUT.
module tb_buzzer_scheduler;

    localparam int TICK    = 10;
    localparam int HI_DIV  = 2;
    localparam int LO_DIV  = 3;
    localparam int KEY_C   = 3 * TICK;
    localparam int BEEP_C  = 4 * TICK;
    localparam int GAP_C   = 4 * TICK;
    localparam int AON_C   = 5 * TICK;
    localparam int AOFF_C  = 5 * TICK;

    localparam int ACT_NONE  = 0;
    localparam int ACT_KEY   = 1;
    localparam int ACT_CHIME = 2;
    localparam int ACT_ALARM = 3;

    logic       clk_100MHz  = 1'b0;
    logic       rst_buzzer  = 1'b1;
    logic       alarm_req   = 1'b0;
    logic       chime_req   = 1'b0;
    logic [3:0] chime_count = 4'd0;
    logic       key_req     = 1'b0;
    logic       mute        = 1'b0;
    logic       buzzer;
    logic       busy;
    logic [1:0] active_src;
    logic       alarm_silenced;

    typedef struct packed {
        logic       buzzer;
        logic       busy;
        logic [1:0] src;
        logic       sil;
    } obs_t;

    obs_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    int   m_act  = ACT_NONE;
    int   m_t    = 0;
    int   m_n    = 0;
    bit   m_pend = 1'b0;
    bit   m_sil  = 1'b0;

    always #5 clk_100MHz = ~clk_100MHz;

    buzzer_scheduler #(
        .TICK_DIV     (TICK),
        .TONE_HI_DIV  (HI_DIV),
        .TONE_LO_DIV  (LO_DIV),
        .KEY_MS       (3),
        .BEEP_MS      (4),
        .GAP_MS       (4),
        .ALARM_ON_MS  (5),
        .ALARM_OFF_MS (5)
    ) dut (
        .clk_100MHz     (clk_100MHz),
        .rst_buzzer     (rst_buzzer),
        .alarm_req      (alarm_req),
        .chime_req      (chime_req),
        .chime_count    (chime_count),
        .key_req        (key_req),
        .mute           (mute),
        .buzzer         (buzzer),
        .busy           (busy),
        .active_src     (active_src),
        .alarm_silenced (alarm_silenced)
    );

    // Expected outputs for the cycle following an edge, from activity and elapsed time.
    function automatic obs_t predict(input bit muted);
        obs_t o;
        int   w;
        bit   on;
        bit   ph;
        o.sil = m_sil;
        on = 1'b0;
        ph = 1'b0;
        case (m_act)
            ACT_KEY: begin
                o.src = 2'b01;
                on = 1'b1;
                ph = ((m_t / HI_DIV) % 2) == 0;
            end
            ACT_CHIME: begin
                o.src = 2'b10;
                w  = m_t % (BEEP_C + GAP_C);
                on = w < BEEP_C;
                ph = ((w / LO_DIV) % 2) == 0;
            end
            ACT_ALARM: begin
                o.src = 2'b11;
                w  = m_t % (AON_C + AOFF_C);
                on = w < AON_C;
                ph = ((w / HI_DIV) % 2) == 0;
            end
            default: o.src = 2'b00;
        endcase
        o.busy   = (m_act != ACT_NONE);
        o.buzzer = on && ph && !muted;
        return o;
    endfunction

    task automatic model_step();
        bit go;
        if (rst_buzzer) begin
            m_act = ACT_NONE; m_t = 0; m_n = 0; m_pend = 1'b0; m_sil = 1'b0;
        end else begin
            go = alarm_req && !m_sil;
            if (m_act == ACT_ALARM) begin
                if (!alarm_req) m_act = ACT_NONE;
                else if (key_req) begin m_act = ACT_NONE; m_sil = 1'b1; end
                else m_t++;
            end else if (go) begin
                m_act = ACT_ALARM; m_t = 0; m_pend = 1'b0;
            end else if (m_act == ACT_KEY) begin
                if (m_t == KEY_C - 1) m_act = ACT_NONE; else m_t++;
            end else if (m_act == ACT_CHIME) begin
                if (key_req) m_pend = 1'b1;
                if (m_t == m_n * BEEP_C + (m_n - 1) * GAP_C - 1) m_act = ACT_NONE;
                else m_t++;
            end else begin
                if (chime_req && chime_count != 4'd0) begin
                    m_act = ACT_CHIME; m_t = 0;
                    m_n = (chime_count > 4'd12) ? 12 : int'(chime_count);
                    m_pend = m_pend | key_req;
                end else if (key_req || m_pend) begin
                    m_act = ACT_KEY; m_t = 0; m_pend = 1'b0;
                end
            end
            if (!alarm_req) m_sil = 1'b0;
        end
        exp_q.push_back(predict(mute));
    endtask

    initial begin
        forever begin
            @(posedge clk_100MHz);
            model_step();
        end
    end

    initial begin
        obs_t e;
        obs_t g;
        forever begin
            @(negedge clk_100MHz);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = '{buzzer: buzzer, busy: busy, src: active_src, sil: alarm_silenced};
                compared++;
                if (g !== e) begin
                    mismatched++;
                    $display("FAIL outputs @%0t got buz=%b busy=%b src=%b sil=%b want buz=%b busy=%b src=%b sil=%b",
                             $time, g.buzzer, g.busy, g.src, g.sil, e.buzzer, e.busy, e.src, e.sil);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_100MHz);
            #1;
        end
    endtask

    task automatic pulse_key();
        key_req = 1'b1; tick(1); key_req = 1'b0;
    endtask

    task automatic pulse_chime(input logic [3:0] cnt);
        chime_count = cnt; chime_req = 1'b1; tick(1); chime_req = 1'b0;
    endtask

    task automatic check_busy_len(input string name, input int window, input int want);
        int n;
        n = 0;
        for (int i = 0; i < window; i++) begin
            @(negedge clk_100MHz);
            if (busy) n++;
        end
        compared++;
        if (n != want) begin
            mismatched++;
            $display("FAIL %s busy cycles got %0d want %0d", name, n, want);
        end
        tick(1);
    endtask

    initial begin
        tick(3);
        rst_buzzer = 1'b0;
        tick(2);
        pulse_key();
        check_busy_len("key_len", 40, KEY_C);
        pulse_chime(4'd3);
        check_busy_len("chime3_len", 250, 3 * BEEP_C + 2 * GAP_C);
        pulse_chime(4'd0);
        tick(20);
        pulse_chime(4'd3);
        tick(BEEP_C + GAP_C + 10);
        alarm_req = 1'b1; tick(230);
        alarm_req = 1'b0; tick(10);
        alarm_req = 1'b1; tick(60);
        pulse_key(); tick(20);
        alarm_req = 1'b0; tick(3);
        alarm_req = 1'b1; tick(30);
        alarm_req = 1'b0; tick(5);
        pulse_chime(4'd2); tick(10);
        pulse_key(); tick(20);
        pulse_key(); tick(150);
        alarm_req = 1'b1; tick(20);
        mute = 1'b1; tick(60);
        mute = 1'b0; alarm_req = 1'b0; tick(5);
        pulse_key(); tick(10);
        rst_buzzer = 1'b1; tick(1);
        rst_buzzer = 1'b0; tick(10);
        pulse_chime(4'd15); tick(950);
        for (int i = 0; i < 4000; i++) begin
            key_req     = ($urandom_range(39) == 0);
            chime_req   = ($urandom_range(199) == 0);
            chime_count = 4'($urandom_range(15));
            rst_buzzer  = ($urandom_range(1999) == 0);
            if ($urandom_range(299) == 0) alarm_req = ~alarm_req;
            if ($urandom_range(149) == 0) mute = ~mute;
            tick(1);
        end
        key_req = 1'b0; chime_req = 1'b0; rst_buzzer = 1'b0;
        tick(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
